mult2c_share_arb: RTL and testbench
===================================

Name: mult2c_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one mult2c_frac_4bit signed Q1.3 fractional multiplier among N_REQ requesters.
- Accepts operand requests and drives the multiplier's st/mcand/mplier.
- Waits for the rising edge of done and returns the Q1.6 product to the granted requester with a one-cycle valid pulse.
- The multiplier is instantiated outside the arbiter; this block is pure control plus operand/result registers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT before aborting with an error.
- DRAIN_CYC, 8, cycles after reset during which no grant is issued, so a multiplier that was mid-operation can finish (the multiplier has no reset).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request level; operands must be stable while high.
- mcand_in  in  4*N_REQ  packed multiplicands; slice i = [4i+3:4i].
- mplier_in  in  4*N_REQ  packed multipliers, same packing.
- ack  out  N_REQ  one-hot one-cycle pulse: operands of requester i sampled.
- rsp_valid  out  N_REQ  one-hot one-cycle pulse: rsp_product/rsp_err valid for requester i.
- rsp_product  out  7  registered Q1.6 product; holds its value between responses.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout, and rsp_product = 0 in that case.
- busy  out  1  high in any state other than IDLE, and during drain.
- mul_st  out  1  start pulse to the multiplier.
- mul_mcand  out  4  registered multiplicand to the multiplier.
- mul_mplier  out  4  registered multiplier operand to the multiplier.
- mul_product  in  7  multiplier result.
- mul_done  in  1  multiplier completion flag; may be a level.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; rr pointer = N_REQ-1, so requester 0 has first priority.
  - Drain counter = DRAIN_CYC; timeout counter 0; done_q 0.
- done_q is a register that samples mul_done every cycle. The done edge is mul_done & ~done_q. It is used only in WAIT.
- Reset mid-operation: all state is abandoned. No rsp_valid is issued for the abandoned operation. Drain restarts.
- States (registered Moore outputs):
  - IDLE: busy = (drain counter != 0).
    - If drain counter != 0: decrement it and ignore req.
    - Else if req != 0: pick the first set bit starting at (rr+1) mod N_REQ, wrapping. Latch mul_mcand/mul_mplier from that slice. Set gidx. Pulse ack[gidx]. Go to START.
  - START: mul_st = 1 for exactly this one cycle; timeout counter cleared. Go to WAIT.
  - WAIT: mul_st = 0; timeout counter increments.
    - On a done edge: capture mul_product; err = 0; go to RESP.
    - Else if count reaches TIMEOUT-1: product = 0; err = 1; go to RESP.
    - If the done edge and timeout coincide, done wins.
  - RESP: rsp_valid[gidx] = 1 for one cycle, with rsp_product/rsp_err driven. rr is set to gidx. Go to IDLE.
- Latency: req sampled at edge E0 →
  - ack visible after E0.
  - mul_st high E0..E1.
  - Multiplier sees st at E1.
  - rsp_valid is high for one cycle, 2 cycles after the done edge is sampled.
- Requester rule: drop or replace req after seeing ack. req is sampled only in IDLE. Requests raised during START/WAIT/RESP wait until the next IDLE, and no ack is lost.
- Fairness: under continuous all-ones req, grants cycle 0,1,…,N_REQ-1,0. A requester waits at most N_REQ-1 operations.
- Arithmetic: no arithmetic is performed on operands. The product is passed through unchanged: 7-bit two's-complement Q1.6, sign at bit 6.
- Operand registers mul_mcand/mul_mplier hold their value until the next grant.

Decomposition:
- Shared package mult2c_pkg:
  - State encoding localparams: IDLE, START, WAIT, RESP.
  - Operand width 4 and product width 7.
  - Q-format constants.
- One natural sub-module: mult2c_rr_pick. Combinational rotate-priority encoder (req, rr pointer → one-hot grant + index). Reused by other shared-resource arbiters.

Test Plan:
- Single request, requester 0:
  - Stimulus: req=0001, mcand_in[3:0]=0101, mplier_in[3:0]=0101, with a real mult2c_frac_4bit attached.
  - Required: ack=0001 one cycle; mul_st high one cycle; rsp_valid=0001 with rsp_product=0011001 (+25/64); rsp_err=0.
- Signed operands, requester 2:
  - Stimulus: req=0100, mcand=1101 (-3/8), mplier=0101.
  - Required: rsp_valid=0100; rsp_product=1110001 (-15/64).
  - Repeat with 1101×1101; required rsp_product=0001001 (+9/64).
- Round-robin order:
  - Stimulus: req=1111 held; each requester drops req for one cycle after its own rsp_valid, then re-raises.
  - Required: ack order 0,1,2,3,0,1. Every rsp_valid matches the gold product of its own operands.
- Timeout:
  - Stimulus: mul_done tied to 0; req=0010.
  - Required: rsp_valid=0010 with rsp_err=1 and rsp_product=0 exactly TIMEOUT+2 cycles after the mul_st cycle. FSM returns to IDLE and the next grant works.
- Reset mid-WAIT:
  - Stimulus: assert rst for one cycle while in WAIT.
  - Required: all outputs 0 the next cycle; no rsp_valid for the aborted operation; busy=1 and no ack for DRAIN_CYC cycles even with req=1111; then ack=0001 first.
- Late request and level done:
  - Stimulus: raise req[3] during WAIT of requester 1's operation; hold mul_done high after completion.
  - Required: the level-high done produces only one response. ack[3] is issued in the first IDLE cycle after RESP.

Source files
------------

// File: rtl/mult2c_pkg.sv
// Shared types and constants for the shared Q1.3 fractional-multiplier arbiter.
package mult2c_pkg;

   // Operand is signed Q1.3, product is signed Q1.6 (sign at bit 6).
   localparam int OP_W           = 4;
   localparam int PROD_W         = 7;
   localparam int OP_FRAC_BITS   = 3;
   localparam int PROD_FRAC_BITS = 6;
   localparam int PROD_SIGN_BIT  = PROD_W - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mult2c_share_arb_if.sv
// Requester-side and multiplier-side signals of the shared multiplier arbiter.
//
// Handshake: a requester holds req[i] high with stable operands until it sees
// the one-cycle ack[i] pulse (operands sampled), then drops or replaces req[i].
// The result arrives later as a one-cycle rsp_valid[i] pulse, qualifying
// rsp_product and rsp_err in that same cycle. There is no back-pressure on
// responses. Toward the multiplier, mul_st is a one-cycle start pulse with
// mul_mcand/mul_mplier stable; completion is the rising edge of mul_done.
interface mult2c_share_arb_if #(
   parameter int N_REQ = 4
);
   import mult2c_pkg::*;

   logic [N_REQ-1:0]      req;
   logic [OP_W*N_REQ-1:0] mcand_in;
   logic [OP_W*N_REQ-1:0] mplier_in;
   logic [N_REQ-1:0]      ack;
   logic [N_REQ-1:0]      rsp_valid;
   logic [PROD_W-1:0]     rsp_product;
   logic                  rsp_err;
   logic                  mul_st;
   logic [OP_W-1:0]       mul_mcand;
   logic [OP_W-1:0]       mul_mplier;
   logic [PROD_W-1:0]     mul_product;
   logic                  mul_done;

   // Arbiter side.
   modport slave (
      input  req, mcand_in, mplier_in, mul_product, mul_done,
      output ack, rsp_valid, rsp_product, rsp_err, mul_st, mul_mcand, mul_mplier
   );

   // Environment side: requesters plus the multiplier.
   modport master (
      output req, mcand_in, mplier_in, mul_product, mul_done,
      input  ack, rsp_valid, rsp_product, rsp_err, mul_st, mul_mcand, mul_mplier
   );

endinterface

// File: rtl/mult2c_rr_pick.sv
// Rotating-priority pick: first set req bit after rr_ptr, wrapping around.
module mult2c_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] gidx,
   output logic             any
);

   // Scan N_REQ positions starting just past rr_ptr; the first hit wins.
   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!any && req[(int'(rr_ptr) + k) % N_REQ]) begin
            any                                  = 1'b1;
            gidx                                 = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            grant[(int'(rr_ptr) + k) % N_REQ]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult2c_share_arb.sv
// Round-robin sequencer sharing one external Q1.3 multiplier among N_REQ
// requesters. Pure control plus operand/result registers.
module mult2c_share_arb
   import mult2c_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int TIMEOUT   = 32,
   parameter int DRAIN_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   mult2c_share_arb_if.slave bus,
   output logic              busy,
   output state_e            dbg_state
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam int DRN_W = $clog2(DRAIN_CYC + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [IDX_W-1:0]    gidx_q, gidx_d;
   logic [DRN_W-1:0]    drain_q, drain_d;
   logic [TMO_W-1:0]    tcnt_q, tcnt_d;
   logic                done_q, done_d;
   logic [PROD_W-1:0]   res_q, res_d;
   logic                err_q, err_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [PROD_W-1:0]   rsp_product_q, rsp_product_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;
   logic                mul_st_q, mul_st_d;
   logic [OP_W-1:0]     mul_mcand_q, mul_mcand_d;
   logic [OP_W-1:0]     mul_mplier_q, mul_mplier_d;

   logic [N_REQ-1:0]    pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic                done_edge;

   mult2c_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_q),
      .grant  (pick_grant),
      .gidx   (pick_idx),
      .any    (pick_any)
   );

   // mul_done may be a level, so only its rising edge counts as completion.
   assign done_edge = bus.mul_done & ~done_q;

   // Next-state and next-output logic; every output is registered (Moore).
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      gidx_d        = gidx_q;
      drain_d       = drain_q;
      tcnt_d        = tcnt_q;
      done_d        = bus.mul_done;
      res_d         = res_q;
      err_d         = err_q;
      ack_d         = '0;
      rsp_valid_d   = '0;
      rsp_product_d = rsp_product_q;
      rsp_err_d     = rsp_err_q;
      mul_st_d      = 1'b0;
      mul_mcand_d   = mul_mcand_q;
      mul_mplier_d  = mul_mplier_q;

      case (state_q)
         ST_IDLE: begin
            if (drain_q != '0) begin
               // Let a multiplier left running across reset finish first.
               drain_d = drain_q - DRN_W'(1);
            end else if (pick_any) begin
               mul_mcand_d  = bus.mcand_in[int'(pick_idx)*OP_W +: OP_W];
               mul_mplier_d = bus.mplier_in[int'(pick_idx)*OP_W +: OP_W];
               gidx_d       = pick_idx;
               ack_d        = pick_grant;
               mul_st_d     = 1'b1;
               state_d      = ST_START;
            end
         end
         ST_START: begin
            tcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tcnt_d = tcnt_q + TMO_W'(1);
            if (done_edge) begin
               res_d   = bus.mul_product;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (tcnt_q == TMO_W'(TIMEOUT - 1)) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid_d[gidx_q] = 1'b1;
            rsp_product_d       = res_q;
            rsp_err_d           = err_q;
            rr_d                = gidx_q;
            state_d             = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE) || (drain_q != '0);
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_q          <= IDX_W'(N_REQ - 1);
         gidx_q        <= '0;
         drain_q       <= DRN_W'(DRAIN_CYC);
         tcnt_q        <= '0;
         done_q        <= 1'b0;
         res_q         <= '0;
         err_q         <= 1'b0;
         ack_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_product_q <= '0;
         rsp_err_q     <= 1'b0;
         busy_q        <= 1'b0;
         mul_st_q      <= 1'b0;
         mul_mcand_q   <= '0;
         mul_mplier_q  <= '0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         gidx_q        <= gidx_d;
         drain_q       <= drain_d;
         tcnt_q        <= tcnt_d;
         done_q        <= done_d;
         res_q         <= res_d;
         err_q         <= err_d;
         ack_q         <= ack_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_product_q <= rsp_product_d;
         rsp_err_q     <= rsp_err_d;
         busy_q        <= busy_d;
         mul_st_q      <= mul_st_d;
         mul_mcand_q   <= mul_mcand_d;
         mul_mplier_q  <= mul_mplier_d;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_product = rsp_product_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.mul_st      = mul_st_q;
   assign bus.mul_mcand   = mul_mcand_q;
   assign bus.mul_mplier  = mul_mplier_q;
   assign busy            = busy_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_mult2c_share_arb.sv
// Bench for mult2c_share_arb with a behavioural signed Q1.3 multiplier attached.
module tb_mult2c_share_arb;
   import mult2c_pkg::*;

   localparam int N_REQ     = 4;
   localparam int TIMEOUT   = 32;
   localparam int DRAIN_CYC = 8;
   localparam int WAIT_MAX  = 200;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   busy;
   state_e dbg_state;
   logic   kill_done = 1'b0;
   int     cyc = 0;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [3:0]  ack_exp_q[$];
   logic [11:0] exp_q[$];
   logic [3:0]  exp_a;
   logic [11:0] exp_r;
   int          st_len = 0;

   mult2c_share_arb_if #(.N_REQ(N_REQ)) bus ();

   mult2c_share_arb #(
      .N_REQ     (N_REQ),
      .TIMEOUT   (TIMEOUT),
      .DRAIN_CYC (DRAIN_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural multiplier (4-cycle, level done, no reset) ----
   logic [3:0] m_a = '0, m_b = '0;
   logic [2:0] m_cnt = '0;
   logic       m_done = 1'b0;
   logic [6:0] m_prod = '0;

   function automatic logic [6:0] prod7(input logic [3:0] a, input logic [3:0] b);
      logic signed [7:0] p;
      p = $signed(a) * $signed(b);
      return p[6:0];
   endfunction

   always @(posedge clk) begin
      if (bus.mul_st) begin
         m_a    <= bus.mul_mcand;
         m_b    <= bus.mul_mplier;
         m_cnt  <= 3'd4;
         m_done <= 1'b0;
      end else if (m_cnt != 3'd0) begin
         m_cnt <= m_cnt - 3'd1;
         if (m_cnt == 3'd1) begin
            m_done <= 1'b1;
            m_prod <= prod7(m_a, m_b);
         end
      end
   end

   assign bus.mul_done    = m_done & ~kill_done;
   assign bus.mul_product = m_prod;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_op(input int i, input logic [6:0] p, input logic err);
      logic [3:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      ack_exp_q.push_back(oh);
      exp_q.push_back({oh, err, p});
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (bus.ack != '0) begin
         if (ack_exp_q.size() == 0) begin
            check("ack_unexpected", 32'(bus.ack), 32'd0);
         end else begin
            exp_a = ack_exp_q.pop_front();
            check("ack_grant", 32'(bus.ack), 32'(exp_a));
            check("ack_with_mul_st", 32'(bus.mul_st), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (bus.rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
         end else begin
            exp_r = exp_q.pop_front();
            check("rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_product}), 32'(exp_r));
         end
      end
   end

   always @(negedge clk) begin
      if (bus.mul_st) begin
         st_len = st_len + 1;
      end else if (st_len != 0) begin
         check("mul_st_width", 32'(st_len), 32'd1);
         st_len = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input int i, output int t);
      bit seen;
      seen = 1'b0;
      t    = 0;
      for (int n = 0; n < WAIT_MAX; n++) begin
         @(negedge clk);
         if (bus.ack[i]) begin
            seen = 1'b1;
            t    = cyc;
            break;
         end
      end
      check("ack_wait", 32'(seen), 32'd1);
   endtask

   task automatic wait_rsp(input int i, output int t);
      bit seen;
      seen = 1'b0;
      t    = 0;
      for (int n = 0; n < WAIT_MAX; n++) begin
         @(negedge clk);
         if (bus.rsp_valid[i]) begin
            seen = 1'b1;
            t    = cyc;
            break;
         end
      end
      check("rsp_wait", 32'(seen), 32'd1);
   endtask

   task automatic wait_state(input state_e s);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < WAIT_MAX; n++) begin
         @(negedge clk);
         if (dbg_state == s) begin
            seen = 1'b1;
            break;
         end
      end
      check("state_wait", 32'(seen), 32'd1);
   endtask

   task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
      bus.mcand_in[4*i +: 4]  = a;
      bus.mplier_in[4*i +: 4] = b;
   endtask

   task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [6:0] p);
      int t;
      set_ops(i, a, b);
      push_op(i, p, 1'b0);
      bus.req[i] = 1'b1;
      wait_ack(i, t);
      bus.req[i] = 1'b0;
      wait_rsp(i, t);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, 32'({bus.ack, bus.rsp_valid, bus.rsp_product, bus.rsp_err, busy,
                       bus.mul_st, bus.mul_mcand, bus.mul_mplier}), 32'd0);
      check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got %0d vectors", vec_cnt);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main stimulus ----------------
   initial begin
      int t0, t1, nack, nrsp;
      logic [3:0] pend;

      bus.req       = '0;
      bus.mcand_in  = '0;
      bus.mplier_in = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst = 1'b0;

      // Single request on requester 0: 5/8 * 5/8 = +25/64.
      do_op(0, 4'b0101, 4'b0101, 7'b0011001);
      repeat (2) @(negedge clk);
      check("rsp_product_hold", 32'(bus.rsp_product), 32'(7'b0011001));
      check("mcand_hold", 32'({bus.mul_mcand, bus.mul_mplier}), 32'(8'b0101_0101));
      check("idle_not_busy", 32'(busy), 32'd0);

      // Signed operands on requester 2.
      do_op(2, 4'b1101, 4'b0101, 7'b1110001);
      do_op(2, 4'b1101, 4'b1101, 7'b0001001);

      // Timeout on requester 1 with done held low.
      kill_done = 1'b1;
      set_ops(1, 4'b0011, 4'b0011);
      push_op(1, 7'b0000000, 1'b1);
      bus.req[1] = 1'b1;
      wait_ack(1, t0);
      bus.req[1] = 1'b0;
      wait_rsp(1, t1);
      check("timeout_latency", 32'(t1 - t0), 32'(TIMEOUT + 2));
      kill_done = 1'b0;
      @(negedge clk);
      check("timeout_back_idle", 32'(dbg_state), 32'(ST_IDLE));
      do_op(1, 4'b0100, 4'b0100, 7'b0010000);

      // Late request during WAIT, with mul_done left as a level afterwards.
      set_ops(1, 4'b0110, 4'b0010);
      set_ops(3, 4'b1111, 4'b0111);
      push_op(1, 7'b0001100, 1'b0);
      push_op(3, 7'b1111001, 1'b0);
      bus.req[1] = 1'b1;
      wait_ack(1, t0);
      bus.req[1] = 1'b0;
      wait_state(ST_WAIT);
      bus.req[3] = 1'b1;
      wait_rsp(1, t0);
      wait_ack(3, t1);
      check("late_ack_after_resp", 32'(t1 - t0), 32'd1);
      bus.req[3] = 1'b0;
      wait_rsp(3, t1);
      repeat (6) @(negedge clk);

      // Reset while in WAIT, then round-robin under all-ones requests.
      set_ops(0, 4'b0011, 4'b0010);
      set_ops(1, 4'b1110, 4'b0100);
      set_ops(2, 4'b0111, 4'b0111);
      set_ops(3, 4'b1000, 4'b0011);
      ack_exp_q.push_back(4'b0010);   // aborted op: ack only, no response
      bus.req[1] = 1'b1;
      wait_ack(1, t0);
      bus.req[1] = 1'b0;
      wait_state(ST_WAIT);
      push_op(0, 7'b0000110, 1'b0);
      push_op(1, 7'b1111000, 1'b0);
      push_op(2, 7'b0110001, 1'b0);
      push_op(3, 7'b1101000, 1'b0);
      push_op(0, 7'b0000110, 1'b0);
      push_op(1, 7'b1111000, 1'b0);
      rst     = 1'b1;
      bus.req = 4'b1111;
      @(negedge clk);
      check_outputs_zero("reset_mid_wait");
      rst = 1'b0;
      for (int k = 0; k < DRAIN_CYC; k++) begin
         @(negedge clk);
         check("drain_busy", 32'(busy), 32'd1);
         check("drain_no_ack", 32'(bus.ack), 32'd0);
      end

      pend = '0;
      nack = 0;
      nrsp = 0;
      for (int c = 0; c < 3000 && nrsp < 6; c++) begin
         if (c != 0) @(negedge clk);
         if (nack < 6) bus.req = bus.req | pend;
         pend = '0;
         if (bus.ack != '0) nack++;
         if (bus.rsp_valid != '0) begin
            nrsp++;
            if (nack < 6) begin
               bus.req = bus.req & ~bus.rsp_valid;
               pend    = bus.rsp_valid;
            end
         end
         if (nack >= 6) bus.req = '0;
      end
      check("rr_responses", 32'(nrsp), 32'd6);
      check("rr_acks", 32'(nack), 32'd6);

      repeat (12) @(negedge clk);
      check("ack_queue_empty", 32'(ack_exp_q.size()), 32'd0);
      check("rsp_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
